shift_seq_ctrl: RTL

//  Multi-bit shift sequencer for the ALU shift path. Accepts one shift command (operand, amount,

---
 rtl/alu_pkg.sv | 19 +
 rtl/shift_seq_ctrl_shift1_step.sv | 30 +++
 rtl/shift_seq_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths, shift-sequencer state encoding
// and the latched shift command.
package alu_pkg;

  localparam int ALU_W   = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  typedef struct packed {
    logic right;
    logic arith;
  } shift_cmd_t;

endpackage

// File: rtl/shift_seq_ctrl_shift1_step.sv
// Combinational single-bit shifter used by the shift sequencer.
// Left shifts always zero-fill; right shifts fill with the sign bit when
// arith is set, otherwise with zero. bit_out is the bit leaving the word.
module shift1_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic             right,
  input  logic             arith,
  output logic [WIDTH-1:0] y,
  output logic             bit_out
);

  logic fill;

  // One-step shift and the bit that falls off the end
  always_comb begin
    fill    = arith & x[WIDTH-1];
    y       = '0;
    bit_out = 1'b0;
    if (right) begin
      y       = {fill, x[WIDTH-1:1]};
      bit_out = x[0];
    end else begin
      y       = {x[WIDTH-2:0], 1'b0};
      bit_out = x[WIDTH-1];
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-bit shift sequencer: accepts one command, applies a 1-bit shift
// per clock for amt cycles, then pulses done with the final result.
// Optional feature macro: SHIFT_COUT_EN adds the cout port, which holds
// the last bit shifted out of the word.
module shift_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int AMT_W = SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_16,
  input  logic [AMT_W-1:0] amt,
  input  logic             right,
  input  logic             arith,
  output logic [WIDTH-1:0] out_16,
  output logic             busy,
  output logic             done
`ifdef SHIFT_COUT_EN
  ,
  output logic             cout
`endif
);

  shift_state_e     state;
  logic [AMT_W-1:0] cnt;
  shift_cmd_t       cmd;
  logic [WIDTH-1:0] step_y;
  logic             step_bit_out;

  shift1_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .x      (out_16),
    .right  (cmd.right),
    .arith  (cmd.arith),
    .y      (step_y),
    .bit_out(step_bit_out)
  );

  // Controller FSM: command latch, step counter, result register, busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      out_16 <= '0;
      cnt    <= '0;
      cmd    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            out_16    <= in_16;
            cnt       <= amt;
            cmd.right <= right;
            cmd.arith <= arith;
            busy      <= 1'b1;
            if (amt != '0) begin
              state <= SHIFT;
            end else begin
              // Zero-length shift: result is the operand, report next cycle
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          out_16 <= step_y;
          cnt    <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          // busy stays high through DONE so a start here is not accepted
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHIFT_COUT_EN
  // Carry-out: cleared on accept, tracks the bit leaving on each step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout <= 1'b0;
    end else if (state == IDLE && start) begin
      cout <= 1'b0;
    end else if (state == SHIFT) begin
      cout <= step_bit_out;
    end
  end
`else
  logic unused_cout;
  assign unused_cout = step_bit_out;
`endif

endmodule
